// File: rtl/nav_pkg.sv
// rtl/nav_pkg.sv - shared types and constants for the obstacle navigator
// State codes, wheel motor codes, sensor bit positions and tick-limit helpers.
package nav_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_STOP   = 3'd2,
    ST_REV    = 3'd3,
    ST_TURN_L = 3'd4,
    ST_TURN_R = 3'd5,
    ST_HALT   = 3'd6
  } nav_state_t;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  localparam int SENS_L = 0;
  localparam int SENS_M = 1;
  localparam int SENS_R = 2;

  // Last tick index of a timed interval; a zero-length interval behaves as one tick.
  function automatic logic [15:0] ms_limit(int ms);
    return (ms < 1) ? 16'd0 : 16'(ms - 1);
  endfunction

  function automatic logic [3:0] motors_of(nav_state_t s);
    case (s)
      ST_FWD:    return {MOT_FWD, MOT_FWD};
      ST_REV:    return {MOT_REV, MOT_REV};
      ST_TURN_L: return {MOT_REV, MOT_FWD};
      ST_TURN_R: return {MOT_FWD, MOT_REV};
      default:   return {MOT_STOP, MOT_STOP};
    endcase
  endfunction

endpackage

// File: rtl/obstacle_navigator_if.sv
// rtl/obstacle_navigator_if.sv - sensor/motor signal bundle of the obstacle navigator
// master = sensor/control side driving flags and enable, slave = the navigator.
interface obstacle_navigator_if;
  logic [2:0] obstacle;
  logic       enable;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic [2:0] obst_filt;
  logic [2:0] nav_state;
  logic       stuck;

  modport master (
    output obstacle, enable,
    input  motor_l, motor_r, obst_filt, nav_state, stuck
  );

  modport slave (
    input  obstacle, enable,
    output motor_l, motor_r, obst_filt, nav_state, stuck
  );
endinterface

// File: rtl/obstacle_debounce.sv
// rtl/obstacle_debounce.sv - 1-bit synchronizer plus tick-based debounce filter
// The filtered value flips only after DEBOUNCE_MS consecutive differing ticks.
module obstacle_debounce
  import nav_pkg::*;
#(
  parameter int DEBOUNCE_MS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic filt
);

  localparam logic [15:0] DB_LIM = ms_limit(DEBOUNCE_MS);

  logic        sync1, sync2;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= 16'd0;
      filt  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        if (sync2 == filt) begin
          cnt <= 16'd0;
        end else if (cnt == DB_LIM) begin
          filt <= ~filt;
          cnt  <= 16'd0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/obstacle_navigator.sv
// rtl/obstacle_navigator.sv - debounced obstacle avoidance FSM driving both wheel motors
// Define NAV_STUCK_EN to build the retry counter that parks the robot in HALT.
module obstacle_navigator
  import nav_pkg::*;
#(
  parameter int TICK_DIV    = 100_000,
  parameter int DEBOUNCE_MS = 16,
  parameter int STOP_MS     = 50,
  parameter int REVERSE_MS  = 300,
  parameter int TURN_MS     = 400,
  parameter int MAX_RETRY   = 4,
  parameter int STUCK_MS    = 1000
) (
  input  logic           fpgaclk,
  input  logic           rst_n,
  obstacle_navigator_if.slave nav
);

  localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] STOP_LIM = ms_limit(STOP_MS);
  localparam logic [15:0] REV_LIM  = ms_limit(REVERSE_MS);
  localparam logic [15:0] TURN_LIM = ms_limit(TURN_MS);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [2:0]    filt;
  nav_state_t    state, nxt, nxt_raw;
  logic [15:0]   timer, lim;
  logic          expired, go_halt;
  logic [1:0]    motor_l, motor_r;

  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge fpgaclk or negedge rst_n) begin
    if (!rst_n) pre_cnt <= '0;
    else        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    obstacle_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk   (fpgaclk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (nav.obstacle[i]),
      .filt  (filt[i])
    );
  end

  always_comb begin
    case (state)
      ST_STOP: lim = STOP_LIM;
      ST_REV:  lim = REV_LIM;
      default: lim = TURN_LIM;
    endcase
  end

  assign expired = tick && (timer == lim);

  always_comb begin
    nxt_raw = state;
    case (state)
      ST_IDLE: nxt_raw = ST_FWD;
      ST_FWD: begin
        if (filt[SENS_M] || (filt[SENS_L] && filt[SENS_R])) nxt_raw = ST_STOP;
        else if (filt[SENS_L])                              nxt_raw = ST_TURN_R;
        else if (filt[SENS_R])                              nxt_raw = ST_TURN_L;
      end
      ST_STOP: if (expired) nxt_raw = ST_REV;
      // Turn away from a left-only obstacle; anything else defaults to a left turn.
      ST_REV: if (expired) nxt_raw = (filt[SENS_L] && !filt[SENS_R]) ? ST_TURN_R : ST_TURN_L;
      ST_TURN_L, ST_TURN_R: if (expired) nxt_raw = ST_FWD;
      default: nxt_raw = state;
    endcase
  end

  assign nxt = !nav.enable ? ST_IDLE : (go_halt ? ST_HALT : nxt_raw);

  always_ff @(posedge fpgaclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= 16'd0;
      motor_l <= MOT_STOP;
      motor_r <= MOT_STOP;
    end else begin
      state              <= nxt;
      timer              <= (nxt != state) ? 16'd0 : (tick ? timer + 16'd1 : timer);
      {motor_l, motor_r} <= motors_of(nxt);
    end
  end

`ifdef NAV_STUCK_EN
  localparam logic [15:0] STUCK_LIM = ms_limit(STUCK_MS);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  logic [7:0]  retry, retry_inc;
  logic [15:0] fwd_cnt;
  logic        fwd_clear, maneuver, stuck_q;

  assign maneuver  = (state == ST_FWD) && (nxt_raw != ST_FWD) && nav.enable;
  assign fwd_clear = (state == ST_FWD) && tick && (fwd_cnt == STUCK_LIM);
  // A clean FWD stretch ending this cycle forgives earlier manoeuvres before counting this one.
  assign retry_inc = (fwd_clear ? 8'd0 : retry) + 8'd1;
  assign go_halt   = maneuver && (retry_inc == RETRY_MAX);

  always_ff @(posedge fpgaclk or negedge rst_n) begin
    if (!rst_n) begin
      retry   <= 8'd0;
      fwd_cnt <= 16'd0;
      stuck_q <= 1'b0;
    end else begin
      if (state == ST_IDLE) retry <= 8'd0;
      else if (maneuver)    retry <= retry_inc;
      else if (fwd_clear)   retry <= 8'd0;

      if (state != ST_FWD) fwd_cnt <= 16'd0;
      else if (tick)       fwd_cnt <= fwd_clear ? 16'd0 : fwd_cnt + 16'd1;

      stuck_q <= (nxt == ST_HALT);
    end
  end

  assign nav.stuck = stuck_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_RETRY[0], STUCK_MS[0]};
  assign go_halt    = 1'b0;
  assign nav.stuck  = 1'b0;
`endif

  assign nav.motor_l   = motor_l;
  assign nav.motor_r   = motor_r;
  assign nav.obst_filt = filt;
  assign nav.nav_state = state;

endmodule

// File: tb/tb_obstacle_navigator.sv
// tb/tb_obstacle_navigator.sv - self-checking bench for obstacle_navigator
// Directed scenarios plus random flags/enable against a behavioural model; NAV_STUCK_EN adds HALT.
module tb_obstacle_navigator;

  localparam int TD      = 10;
  localparam int DB      = 3;
  localparam int STOP_T  = 5;
  localparam int REV_T   = 8;
  localparam int TURN_T  = 6;
  localparam int MAXR    = 4;
  localparam int STUCK_T = 20;

  localparam logic [2:0] S_IDLE = 3'd0, S_FWD = 3'd1, S_STOP = 3'd2, S_REV = 3'd3;
  localparam logic [2:0] S_TL = 3'd4, S_TR = 3'd5, S_HALT = 3'd6;

  logic fpgaclk = 1'b0;
  logic rst_n;
  always #5 fpgaclk = ~fpgaclk;

  obstacle_navigator_if nav();

  obstacle_navigator #(
    .TICK_DIV(TD), .DEBOUNCE_MS(DB), .STOP_MS(STOP_T), .REVERSE_MS(REV_T),
    .TURN_MS(TURN_T), .MAX_RETRY(MAXR), .STUCK_MS(STUCK_T)
  ) dut (
    .fpgaclk (fpgaclk),
    .rst_n   (rst_n),
    .nav     (nav)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [2:0] m_st, m_filt;
  int         m_cyc, m_left, m_retry, m_fwd;
  int         m_diff [3];
  logic [2:0] m_hist [$];
  bit         m_tick;

  function automatic logic [3:0] exp_motors(logic [2:0] s);
    case (s)
      S_FWD:   return 4'b0101;
      S_REV:   return 4'b1010;
      S_TL:    return 4'b1001;
      S_TR:    return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int at_least1(int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int dur_of(logic [2:0] s);
    case (s)
      S_STOP:  return STOP_T;
      S_REV:   return REV_T;
      default: return TURN_T;
    endcase
  endfunction

  always @(posedge fpgaclk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = S_IDLE; m_filt = 3'b000; m_cyc = 0; m_left = 0; m_retry = 0; m_fwd = 0; m_tick = 0;
      m_hist = {};
      m_hist.push_back(3'b000);
      m_hist.push_back(3'b000);
      for (int b = 0; b < 3; b++) m_diff[b] = 0;
    end else begin : step
      logic [2:0] nst, samp;
      m_tick = (m_cyc % TD) == (TD - 1);
      m_cyc++;
      nst = m_st;
      if (m_st != S_FWD) m_fwd = 0;
      if (m_st == S_IDLE) m_retry = 0;
      if (m_st == S_FWD && m_tick) begin
        m_fwd++;
        if (m_fwd == STUCK_T) begin m_fwd = 0; m_retry = 0; end
      end
      if (m_st == S_IDLE) nst = S_FWD;
      else if (m_st == S_FWD) begin
        if (m_filt[1] || (m_filt[0] && m_filt[2])) nst = S_STOP;
        else if (m_filt[0])                        nst = S_TR;
        else if (m_filt[2])                        nst = S_TL;
      end else if ((m_st inside {S_STOP, S_REV, S_TL, S_TR}) && m_tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_st == S_STOP)     nst = S_REV;
          else if (m_st == S_REV) nst = (m_filt[0] && !m_filt[2]) ? S_TR : S_TL;
          else                    nst = S_FWD;
        end
      end
`ifdef NAV_STUCK_EN
      if (m_st == S_FWD && nst != S_FWD && nav.enable) begin
        m_retry++;
        if (m_retry == MAXR) nst = S_HALT;
      end
`endif
      if (!nav.enable) nst = S_IDLE;
      if (nst != m_st) m_left = at_least1(dur_of(nst));
      m_st = nst;
      samp = m_hist.pop_front();
      m_hist.push_back(nav.obstacle);
      if (m_tick) begin
        for (int b = 0; b < 3; b++) begin
          if (samp[b] == m_filt[b]) m_diff[b] = 0;
          else begin
            m_diff[b]++;
            if (m_diff[b] >= at_least1(DB)) begin m_filt[b] = ~m_filt[b]; m_diff[b] = 0; end
          end
        end
      end
    end
  end

  always @(negedge fpgaclk) begin
    if (chk_en && rst_n) begin
      vectors++;
      if ({nav.nav_state, nav.motor_l, nav.motor_r, nav.obst_filt, nav.stuck} !==
          {m_st, exp_motors(m_st), m_filt, (m_st == S_HALT)}) begin
        miscompares++;
        $display("FAIL model t=%0t state=%0d exp %0d motors=%b%b exp %b filt=%b exp %b stuck=%b",
                 $time, nav.nav_state, m_st, nav.motor_l, nav.motor_r, exp_motors(m_st),
                 nav.obst_filt, m_filt, nav.stuck);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound);
    int c = 0;
    while (nav.nav_state !== s && c < bound) begin
      @(negedge fpgaclk);
      c++;
    end
    vectors++;
    if (nav.nav_state !== s) begin
      miscompares++;
      $display("FAIL wait_state: state %0d expected %0d within %0d cycles", nav.nav_state, s, bound);
    end
  endtask

  task automatic dwell(input string name, input logic [2:0] s, input int exp);
    int n = 0;
    int c = 0;
    while (nav.nav_state === s && c < 2000) begin
      @(negedge fpgaclk);
      c++;
      if (m_tick) n++;
    end
    check(name, 16'(n), 16'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    nav.obstacle = 3'b000;
    nav.enable = 1'b0;
    repeat (3) @(negedge fpgaclk);
    check("reset_state", 16'(nav.nav_state), 16'd0);
    check("reset_outs", 16'({nav.motor_l, nav.motor_r, nav.obst_filt, nav.stuck}), 16'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    @(negedge fpgaclk);
    nav.enable = 1'b1;
    repeat (5) @(negedge fpgaclk);
    check("fwd_state", 16'(nav.nav_state), 16'(S_FWD));
    check("fwd_motors", 16'({nav.motor_l, nav.motor_r}), 16'b0101);

    nav.obstacle = 3'b010;
    repeat (20) @(negedge fpgaclk);
    nav.obstacle = 3'b000;
    repeat (60) @(negedge fpgaclk);
    check("glitch_filt", 16'(nav.obst_filt), 16'd0);
    check("glitch_state", 16'(nav.nav_state), 16'(S_FWD));

    nav.obstacle = 3'b010;
    wait_state(S_STOP, 200);
    check("mid_filt", 16'(nav.obst_filt), 16'b010);
    nav.obstacle = 3'b000;
    dwell("stop_ticks", S_STOP, STOP_T);
    dwell("rev_ticks", S_REV, REV_T);
    check("turn_l_state", 16'(nav.nav_state), 16'(S_TL));
    check("turn_l_motors", 16'({nav.motor_l, nav.motor_r}), 16'b1001);
    dwell("turn_l_ticks", S_TL, TURN_T);
    check("after_turn", 16'(nav.nav_state), 16'(S_FWD));

    nav.obstacle = 3'b001;
    wait_state(S_TR, 200);
    check("turn_r_motors", 16'({nav.motor_l, nav.motor_r}), 16'b0110);
    dwell("turn_r_ticks", S_TR, TURN_T);
    check("turn_r_exit", 16'(nav.nav_state), 16'(S_FWD));
    wait_state(S_TR, 3);
    nav.obstacle = 3'b000;
    wait_state(S_FWD, 200);

    nav.enable = 1'b0;
    repeat (2) @(negedge fpgaclk);
    check("disable_idle", 16'(nav.nav_state), 16'(S_IDLE));
    nav.enable = 1'b1;
    nav.obstacle = 3'b010;
    wait_state(S_REV, 600);
    nav.obstacle = 3'b000;
    repeat (30) @(negedge fpgaclk);
    nav.enable = 1'b0;
    @(negedge fpgaclk);
    check("abort_rev_state", 16'(nav.nav_state), 16'(S_IDLE));
    check("abort_rev_motors", 16'({nav.motor_l, nav.motor_r}), 16'd0);

    nav.enable = 1'b1;
    nav.obstacle = 3'b100;
    wait_state(S_TL, 200);
    repeat (20) @(negedge fpgaclk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_state", 16'(nav.nav_state), 16'd0);
    check("rst_mid_outs", 16'({nav.motor_l, nav.motor_r, nav.obst_filt, nav.stuck}), 16'd0);
    nav.obstacle = 3'b000;
    @(negedge fpgaclk);
    rst_n = 1'b1;
    repeat (5) @(negedge fpgaclk);
    check("post_rst_state", 16'(nav.nav_state), 16'(S_FWD));

    for (int i = 0; i < 120; i++) begin
      nav.obstacle = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      nav.enable = ($urandom_range(0, 15) != 0);
      repeat ($urandom_range(1, 60)) @(negedge fpgaclk);
    end

`ifdef NAV_STUCK_EN
    nav.enable = 1'b0;
    nav.obstacle = 3'b000;
    repeat (2) @(negedge fpgaclk);
    nav.enable = 1'b1;
    nav.obstacle = 3'b010;
    wait_state(S_HALT, 2000);
    check("halt_stuck", 16'(nav.stuck), 16'd1);
    check("halt_motors", 16'({nav.motor_l, nav.motor_r}), 16'd0);
    nav.obstacle = 3'b000;
    nav.enable = 1'b0;
    @(negedge fpgaclk);
    check("halt_exit", 16'({nav.nav_state, nav.stuck}), 16'd0);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
